// File: rtl/t2mi_bbf_header_gen.sv
// T2-MI baseband-frame header generator: emits the 19-byte T2-MI/payload/BBHEADER
// sequence with a trailing CRC-8 byte, and tracks packet/block/frame/superframe counters.
module t2mi_bbf_header_gen (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic [7:0]  plp_id,
    input  logic        nm_or_hem,
    input  logic [9:0]  plp_num_blocks,
    input  logic [7:0]  num_t2_frames,
    input  logic [15:0] k_bch,
    input  logic [15:0] syncd,
    input  logic        HDR_READY,
    output logic [7:0]  HDR_DATA,
    output logic        HDR_VALID,
    output logic        HDR_LAST,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CRC = 2'd2} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [7:0]  plp_q, plp_d;
    logic        nm_q, nm_d;
    logic [15:0] kbch_q, kbch_d;
    logic [15:0] syncd_q, syncd_d;
    logic [7:0]  crc_q, crc_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;
    logic [7:0]  pkt_cnt_q, pkt_cnt_d;
    logic [9:0]  blk_cnt_q, blk_cnt_d;
    logic [7:0]  frm_idx_q, frm_idx_d;
    logic [3:0]  sf_idx_q, sf_idx_d;

    logic        accept_s;
    logic [4:0]  nxt_idx_s;
    logic [7:0]  nxt_byte_s;
    logic [7:0]  crc_upd_s;
    logic [15:0] payload_len_s;
    logic [15:0] dfl_s;
    logic [15:0] upl_s;
    logic [7:0]  sync_s;
    logic [9:0]  blk_lim_s;
    logic [7:0]  frm_lim_s;

    // CRC-8, polynomial 0xD5, MSB first, one byte per call
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'hD5) : (c << 1);
        end
        return c;
    endfunction

    // Field values derived from the latched parameters and current counter limits
    always_comb begin
        accept_s      = valid_q && HDR_READY;
        nxt_idx_s     = idx_q + 5'd1;
        crc_upd_s     = crc8_update(crc_q, data_q);
        payload_len_s = kbch_q + 16'd24;
        dfl_s         = kbch_q - 16'd80;
        upl_s         = nm_q ? 16'h0000 : 16'h05E0;
        sync_s        = nm_q ? 8'h00 : 8'h47;
        blk_lim_s     = (plp_num_blocks == 10'd0) ? 10'd0 : (plp_num_blocks - 10'd1);
        frm_lim_s     = (num_t2_frames == 8'd0) ? 8'd0 : (num_t2_frames - 8'd1);
    end

    // Header byte that follows the one currently presented
    always_comb begin
        case (nxt_idx_s)
            5'd1:    nxt_byte_s = pkt_cnt_q;
            5'd2:    nxt_byte_s = {sf_idx_q, 4'h0};
            5'd3:    nxt_byte_s = 8'h00;
            5'd4:    nxt_byte_s = payload_len_s[15:8];
            5'd5:    nxt_byte_s = payload_len_s[7:0];
            5'd6:    nxt_byte_s = frm_idx_q;
            5'd7:    nxt_byte_s = plp_q;
            5'd8:    nxt_byte_s = {(blk_cnt_q == 10'd0), 7'b0};
            5'd9:    nxt_byte_s = 8'hF0;
            5'd10:   nxt_byte_s = plp_q;
            5'd11:   nxt_byte_s = upl_s[15:8];
            5'd12:   nxt_byte_s = upl_s[7:0];
            5'd13:   nxt_byte_s = dfl_s[15:8];
            5'd14:   nxt_byte_s = dfl_s[7:0];
            5'd15:   nxt_byte_s = sync_s;
            5'd16:   nxt_byte_s = syncd_q[15:8];
            5'd17:   nxt_byte_s = syncd_q[7:0];
            default: nxt_byte_s = 8'h00;
        endcase
    end

    // Sequencer next-state, output and counter logic
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        plp_d     = plp_q;
        nm_d      = nm_q;
        kbch_d    = kbch_q;
        syncd_d   = syncd_q;
        crc_d     = crc_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        pkt_cnt_d = pkt_cnt_q;
        blk_cnt_d = blk_cnt_q;
        frm_idx_d = frm_idx_q;
        sf_idx_d  = sf_idx_q;
        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d = SEND;
                    idx_d   = 5'd0;
                    plp_d   = plp_id;
                    nm_d    = nm_or_hem;
                    kbch_d  = k_bch;
                    syncd_d = syncd;
                    crc_d   = 8'h00;
                    data_d  = 8'h00;
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (accept_s) begin
                    idx_d = nxt_idx_s;
                    if (idx_q >= 5'd9) begin
                        crc_d = crc_upd_s;
                    end else begin
                        crc_d = crc_q;
                    end
                    if (idx_q == 5'd17) begin
                        // CRC byte: LSB flipped for HEM so the mode is self-identifying
                        state_d = CRC;
                        data_d  = crc_upd_s ^ {7'b0, nm_q};
                        last_d  = 1'b1;
                    end else begin
                        data_d  = nxt_byte_s;
                    end
                end else begin
                    state_d = SEND;
                end
            end
            CRC: begin
                if (accept_s) begin
                    state_d   = IDLE;
                    idx_d     = 5'd0;
                    data_d    = 8'h00;
                    valid_d   = 1'b0;
                    last_d    = 1'b0;
                    pkt_cnt_d = pkt_cnt_q + 8'd1;
                    // >= rather than == so a counter beyond a reduced limit still wraps
                    if (blk_cnt_q >= blk_lim_s) begin
                        blk_cnt_d = 10'd0;
                        if (frm_idx_q >= frm_lim_s) begin
                            frm_idx_d = 8'd0;
                            sf_idx_d  = sf_idx_q + 4'd1;
                        end else begin
                            frm_idx_d = frm_idx_q + 8'd1;
                        end
                    end else begin
                        blk_cnt_d = blk_cnt_q + 10'd1;
                    end
                end else begin
                    state_d = CRC;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            idx_q     <= 5'd0;
            plp_q     <= 8'h00;
            nm_q      <= 1'b0;
            kbch_q    <= 16'h0000;
            syncd_q   <= 16'h0000;
            crc_q     <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            pkt_cnt_q <= 8'd0;
            blk_cnt_q <= 10'd0;
            frm_idx_q <= 8'd0;
            sf_idx_q  <= 4'd0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            plp_q     <= plp_d;
            nm_q      <= nm_d;
            kbch_q    <= kbch_d;
            syncd_q   <= syncd_d;
            crc_q     <= crc_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            pkt_cnt_q <= pkt_cnt_d;
            blk_cnt_q <= blk_cnt_d;
            frm_idx_q <= frm_idx_d;
            sf_idx_q  <= sf_idx_d;
        end
    end

    assign HDR_DATA  = data_q;
    assign HDR_VALID = valid_q;
    assign HDR_LAST  = last_q;
    assign BUSY      = busy_q;

endmodule

// File: tb/tb_t2mi_bbf_header_gen.sv
// Self-checking bench for t2mi_bbf_header_gen: vector table, directed counter
// sequences and randomized packets against a whole-packet reference model.
module tb_t2mi_bbf_header_gen;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [7:0]  plp_id = 8'h00;
    logic        nm_or_hem = 1'b0;
    logic [9:0]  plp_num_blocks = 10'd1;
    logic [7:0]  num_t2_frames = 8'd1;
    logic [15:0] k_bch = 16'h0000;
    logic [15:0] syncd = 16'h0000;
    logic        HDR_READY = 1'b0;
    logic [7:0]  HDR_DATA;
    logic        HDR_VALID;
    logic        HDR_LAST;
    logic        BUSY;

    t2mi_bbf_header_gen dut (
        .CLK(CLK), .RST(RST), .START(START), .plp_id(plp_id), .nm_or_hem(nm_or_hem),
        .plp_num_blocks(plp_num_blocks), .num_t2_frames(num_t2_frames), .k_bch(k_bch),
        .syncd(syncd), .HDR_READY(HDR_READY), .HDR_DATA(HDR_DATA), .HDR_VALID(HDR_VALID),
        .HDR_LAST(HDR_LAST), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int m_pkt = 0, m_blk = 0, m_frm = 0, m_sf = 0;
    logic [7:0] got [19];

    typedef struct {
        logic [15:0] k;
        logic [7:0]  plp;
        logic        nm;
        logic [15:0] sy;
        bit          stall;
        logic [15:0] exp_pl;
        logic [15:0] exp_dfl;
        logic [7:0]  exp_sync;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // CRC-8 as polynomial long division of the message by x^8+x^7+x^6+x^4+x^2+1
    function automatic logic [7:0] crc_div(input logic [71:0] msg);
        logic [79:0] r;
        r = {msg, 8'h00};
        for (int i = 79; i >= 8; i--)
            if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h1D5;
        return r[7:0];
    endfunction

    function automatic logic [71:0] pack_bbh();
        logic [71:0] m;
        for (int i = 0; i < 9; i++) m[71 - 8*i -: 8] = got[9 + i];
        return m;
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0; HDR_READY = 1'b0; START = 1'b0;
        #1;
        chk("rst_valid", HDR_VALID, 1'b0);
        chk("rst_last",  HDR_LAST,  1'b0);
        chk("rst_busy",  BUSY,      1'b0);
        chk("rst_data",  HDR_DATA,  8'h00);
        @(negedge CLK);
        RST = 1'b1;
        m_pkt = 0; m_blk = 0; m_frm = 0; m_sf = 0;
    endtask

    // One header sequence; start_at/rst_at >= 0 inject START or a reset pulse at that byte
    task automatic run_packet(input logic [15:0] k, input logic [7:0] plp, input logic nm,
                              input logic [15:0] sy, input bit stall,
                              input int start_at, input int rst_at);
        logic [7:0]  e [19];
        logic [15:0] pl, dfl;
        logic [71:0] bbh;
        logic [7:0]  held;
        bit          have_stall, started;
        int          kb, cyc, blim, flim;
        pl  = k + 16'd24;
        dfl = k - 16'd80;
        e[0] = 8'h00; e[1] = 8'(m_pkt); e[2] = 8'(m_sf << 4); e[3] = 8'h00;
        e[4] = pl[15:8]; e[5] = pl[7:0]; e[6] = 8'(m_frm); e[7] = plp;
        e[8] = (m_blk == 0) ? 8'h80 : 8'h00;
        e[9] = 8'hF0; e[10] = plp;
        e[11] = nm ? 8'h00 : 8'h05; e[12] = nm ? 8'h00 : 8'hE0;
        e[13] = dfl[15:8]; e[14] = dfl[7:0]; e[15] = nm ? 8'h00 : 8'h47;
        e[16] = sy[15:8]; e[17] = sy[7:0];
        bbh = {e[9], e[10], e[11], e[12], e[13], e[14], e[15], e[16], e[17]};
        e[18] = crc_div(bbh) ^ {7'b0, nm};

        @(negedge CLK);
        START = 1'b1; k_bch = k; plp_id = plp; nm_or_hem = nm; syncd = sy; HDR_READY = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        k_bch = 16'($urandom); plp_id = 8'($urandom); nm_or_hem = ~nm; syncd = 16'($urandom);
        chk("latency_valid", HDR_VALID, 1'b1);
        chk("busy_high", BUSY, 1'b1);
        kb = 0; cyc = 0; have_stall = 0; started = 0;
        while (kb < 19 && cyc < 2000) begin
            if (have_stall) chk($sformatf("stable_b%0d", kb), HDR_DATA, held);
            if (!HDR_VALID) chk($sformatf("valid_hold_b%0d", kb), HDR_VALID, 1'b1);
            if (rst_at == kb) begin
                RST = 1'b0; HDR_READY = 1'b0;
                #1;
                chk("midrst_valid", HDR_VALID, 1'b0);
                chk("midrst_busy",  BUSY,      1'b0);
                chk("midrst_data",  HDR_DATA,  8'h00);
                chk("midrst_last",  HDR_LAST,  1'b0);
                @(negedge CLK);
                RST = 1'b1;
                m_pkt = 0; m_blk = 0; m_frm = 0; m_sf = 0;
                return;
            end
            if (start_at == kb && !started) begin
                START = 1'b1; started = 1;
            end
            HDR_READY = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (HDR_READY) begin
                got[kb] = HDR_DATA;
                chk($sformatf("byte%0d", kb), HDR_DATA, e[kb]);
                chk($sformatf("last_b%0d", kb), HDR_LAST, (kb == 18));
                kb++;
                have_stall = 0;
            end else begin
                have_stall = 1;
                held = HDR_DATA;
            end
            @(negedge CLK);
            START = 1'b0;
            cyc++;
        end
        if (kb < 19) chk("timeout", kb, 19);
        HDR_READY = 1'b0;
        chk("end_valid", HDR_VALID, 1'b0);
        chk("end_busy", BUSY, 1'b0);
        if (started) begin
            repeat (2) @(negedge CLK);
            chk("ignored_start", HDR_VALID, 1'b0);
        end
        blim = (plp_num_blocks == 0) ? 0 : int'(plp_num_blocks) - 1;
        flim = (num_t2_frames == 0) ? 0 : int'(num_t2_frames) - 1;
        m_pkt = (m_pkt + 1) % 256;
        if (m_blk >= blim) begin
            m_blk = 0;
            if (m_frm >= flim) begin m_frm = 0; m_sf = (m_sf + 1) % 16; end
            else m_frm++;
        end else m_blk++;
    endtask

    localparam logic [143:0] REF_NM = 144'h00000000_1B900005_80F00505_E01B2847_0000;

    initial begin
        vec_t vt [5];
        int   exp_frm [9];
        int   exp_sf [9];
        logic [143:0] ref_nm;
        logic [7:0] ref_b;
        vt[0] = '{16'd7032,  8'h05, 1'b0, 16'h0000, 1'b0, 16'h1B90, 16'h1B28, 8'h47};
        vt[1] = '{16'd7032,  8'h05, 1'b1, 16'h0000, 1'b1, 16'h1B90, 16'h1B28, 8'h00};
        vt[2] = '{16'd0,     8'h3C, 1'b0, 16'hBEEF, 1'b1, 16'h0018, 16'hFFB0, 8'h47};
        vt[3] = '{16'd65535, 8'hA5, 1'b1, 16'h1234, 1'b1, 16'h0017, 16'hFFAF, 8'h00};
        vt[4] = '{16'd80,    8'h7E, 1'b0, 16'h00FF, 1'b0, 16'h0068, 16'h0000, 8'h47};
        exp_frm = '{0, 0, 1, 1, 0, 0, 1, 1, 0};
        exp_sf  = '{0, 0, 0, 0, 1, 1, 1, 1, 2};
        ref_nm  = REF_NM;

        #1;
        chk("por_valid", HDR_VALID, 1'b0);
        chk("por_busy",  BUSY,      1'b0);
        chk("por_data",  HDR_DATA,  8'h00);
        do_reset();

        plp_num_blocks = 10'd1; num_t2_frames = 8'd1;
        for (int v = 0; v < 5; v++) begin
            run_packet(vt[v].k, vt[v].plp, vt[v].nm, vt[v].sy, vt[v].stall, -1, -1);
            chk($sformatf("v%0d_pl", v),   {got[4], got[5]},   vt[v].exp_pl);
            chk($sformatf("v%0d_dfl", v),  {got[13], got[14]}, vt[v].exp_dfl);
            chk($sformatf("v%0d_sync", v), got[15],            vt[v].exp_sync);
            if (v == 0)
                for (int i = 0; i < 18; i++) begin
                    ref_b = ref_nm[143 - 8*i -: 8];
                    chk($sformatf("ref_b%0d", i), got[i], ref_b);
                end
            if (vt[v].nm)
                chk($sformatf("v%0d_hem_crc_lsb", v), got[18] ^ crc_div(pack_bbh()), 8'h01);
        end

        // START while busy is ignored, then a reset pulse mid-packet
        run_packet(16'd7032, 8'h05, 1'b0, 16'h0000, 1'b1, 4, -1);
        run_packet(16'd7032, 8'h05, 1'b0, 16'h0000, 1'b0, 3, 10);
        run_packet(16'd7032, 8'h05, 1'b0, 16'h0000, 1'b1, -1, -1);
        chk("post_rst_pkt", got[1], 8'h00);
        chk("post_rst_ifs", got[8], 8'h80);

        do_reset();
        plp_num_blocks = 10'd2; num_t2_frames = 8'd2;
        for (int p = 0; p < 9; p++) begin
            run_packet(16'd7032, 8'h11, 1'b0, 16'h0001, 1'b0, -1, -1);
            chk($sformatf("seq_frm%0d", p), got[6], exp_frm[p]);
            chk($sformatf("seq_sf%0d", p),  got[2], exp_sf[p] << 4);
            chk($sformatf("seq_ifs%0d", p), got[8], (p % 2 == 0) ? 8'h80 : 8'h00);
        end

        do_reset();
        plp_num_blocks = 10'd0; num_t2_frames = 8'd0;
        for (int p = 0; p < 4; p++) begin
            run_packet(16'd1000, 8'h22, 1'b1, 16'h0002, 1'b0, -1, -1);
            chk($sformatf("zero_ifs%0d", p), got[8], 8'h80);
            chk($sformatf("zero_frm%0d", p), got[6], 8'h00);
            chk($sformatf("zero_sf%0d", p),  got[2], p << 4);
        end

        // Randomized packets with shifting limits exercise the over-limit wrap
        for (int p = 0; p < 20; p++) begin
            plp_num_blocks = 10'($urandom_range(0, 4));
            num_t2_frames  = 8'($urandom_range(0, 3));
            run_packet(16'($urandom), 8'($urandom), 1'($urandom), 16'($urandom),
                       1'($urandom), -1, -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/t2mi_bbf_header_gen.md
T2MI_BBF_HEADER_GEN -- requirements
Module: t2mi_bbf_header_gen

Interface
REQ-001 SHALL have port CLK, input, 1, system clock; all state changes on its rising edge.
REQ-002 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port START, input, 1, single-cycle request to emit one header sequence.
REQ-004 SHALL have port plp_id, input, 8, PLP identifier from the L1 parameter stage.
REQ-005 SHALL have port nm_or_hem, input, 1, 0 = NM, 1 = HEM.
REQ-006 SHALL have port plp_num_blocks, input, 10, BB frames per interleaving frame.
REQ-007 SHALL have port num_t2_frames, input, 8, T2 frames per superframe.
REQ-008 SHALL have port k_bch, input, 16, BCH payload size in bits.
REQ-009 SHALL have port syncd, input, 16, SYNCD value for the current BB frame.
REQ-010 SHALL have port HDR_READY, input, 1, downstream accepts the byte this cycle.
REQ-011 SHALL have port HDR_DATA, output, 8, header byte.
REQ-012 SHALL have port HDR_VALID, output, 1, HDR_DATA valid.
REQ-013 SHALL have port HDR_LAST, output, 1, high with final byte (index 18).
REQ-014 SHALL have port BUSY, output, 1, high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, SEND, CRC; IDLE->SEND on START; SEND->CRC when byte 17 is accepted; CRC->IDLE when byte 18 is accepted.
REQ-016 SHALL latch plp_id, nm_or_hem, k_bch and syncd on the START cycle; input changes mid-sequence have no effect.
REQ-017 SHALL ignore START while BUSY=1.
REQ-018 SHALL assert HDR_VALID on the cycle after START (latency 1), holding HDR_DATA stable until HDR_READY=1.
REQ-019 SHALL advance the byte index 0..18 only on HDR_VALID && HDR_READY.
REQ-020 SHALL emit T2-MI header bytes 0-5: 0x00 (packet_type), packet_count, {superframe_idx[3:0],4'h0}, 0x00, payload_len[15:8], payload_len[7:0], where payload_len = k_bch + 24, truncated to 16 bits.
REQ-021 SHALL emit payload header bytes 6-8: frame_idx, plp_id, {intl_frame_start,7'b0}; intl_frame_start = 1 when block_cnt = 0.
REQ-022 SHALL emit BBHEADER bytes 9-17: 0xF0 (MATYPE-1), plp_id (MATYPE-2), UPL hi/lo, DFL hi/lo, SYNC, syncd hi/lo.
REQ-023 SHALL use UPL = 1504 (0x05E0) and SYNC = 0x47 when nm_or_hem=0, and UPL = 0x0000 and SYNC = 0x00 when nm_or_hem=1.
REQ-024 SHALL compute DFL = k_bch - 80, modulo 2^16.
REQ-025 SHALL compute CRC-8 (polynomial 0xD5, init 0x00, MSB first) over bytes 9-17, updated as each byte is accepted, and emit byte 18 = CRC XOR {7'b0, latched nm_or_hem}.
REQ-026 SHALL, on acceptance of byte 18, increment packet_count modulo 256 and increment block_cnt.
REQ-027 SHALL wrap block_cnt to 0 when it reaches max(plp_num_blocks,1)-1, and on that wrap increment frame_idx.
REQ-028 SHALL wrap frame_idx to 0 when it reaches max(num_t2_frames,1)-1, and on that wrap increment superframe_idx modulo 16.
REQ-029 SHALL, if any counter already exceeds its limit after a parameter change, wrap it to 0 on its next increment.

Reset
REQ-030 SHALL, on RST=0, immediately force state IDLE, byte index 0, HDR_VALID=0, HDR_LAST=0, BUSY=0, HDR_DATA=0x00, and CRC, packet_count, block_cnt, frame_idx and superframe_idx all 0, including mid-sequence.
REQ-031 SHALL resume normal operation on the first rising CLK edge after RST deasserts, with the first packet carrying packet_count 0, frame_idx 0 and intl_frame_start 1.

Verification
REQ-032 SHALL cover: reset, then START with k_bch=7032, plp_id=0x05, NM, syncd=0x0000, HDR_READY=1 -> 19 consecutive bytes 00 00 00 00 1B 90 00 05 80 F0 05 05 E0 1B 28 47 00 00 CRC, with HDR_LAST on byte 18.
REQ-033 SHALL cover: same stimulus with nm_or_hem=1 -> UPL and SYNC bytes 0x00, and byte 18 LSB inverted relative to the CRC over the emitted bytes 9-17.
REQ-034 SHALL cover: HDR_READY toggled randomly -> HDR_DATA stable while stalled, no byte lost or duplicated, and the same 19-byte sequence as the no-stall case.
REQ-035 SHALL cover: plp_num_blocks=2, num_t2_frames=2, 9 packets -> frame_idx 0,0,1,1,0,0,1,1,0; superframe_idx increments after packet 4 and again after packet 8; intl_frame_start 1 on odd-numbered packets.
REQ-036 SHALL cover: START asserted during BUSY, and RST pulsed at byte 10 -> the START is ignored; after the reset pulse the outputs are idle and the next packet's packet_count is 0.
REQ-037 SHALL cover: plp_num_blocks=0 and num_t2_frames=0 -> each packet has intl_frame_start=1 and frame_idx=0, and superframe_idx increments on every packet.
